fulladder32_seq_ctrl: RTL and testbench
=======================================

FULLADDER32_SEQ_CTRL -- requirements
Module: fulladder32_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NWORDS, default 4, giving the number of 32-bit words per operand (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: request holds valid operands.
REQ-005 The block SHALL have port in_ready, output, 1 bit: controller can accept a request.
REQ-006 The block SHALL have ports in_a and in_b, input, 32*NWORDS bits each: wide operands, word k at bits [32k+31:32k].
REQ-007 The block SHALL have port in_cin, input, 1 bit: carry-in to word 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-010 The block SHALL have port out_sum, output, 32*NWORDS bits: registered wide result.
REQ-011 The block SHALL have ports out_cout and out_ovf, output, 1 bit each: final carry-out and signed overflow.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-013 The block SHALL contain exactly one 32-bit adder instance (the team's existing FullAdder32: a, b, cin -> sum, cout) and SHALL sequence every wide add through it, one word per cycle.
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE, with in_ready high only in IDLE.
REQ-015 The handshake in_valid && in_ready SHALL register in_a, in_b and the initial carry, clear the word index to 0, and move the FSM to RUN.
REQ-016 Each RUN cycle SHALL add word k of the registered operands plus the carry register, write the sum into word k of out_sum, store cout as the next carry, and increment k.
REQ-017 Processing word NWORDS-1 SHALL move the FSM to DONE, so out_valid rises exactly NWORDS clock edges after the acceptance edge.
REQ-018 In DONE, out_valid SHALL be high and out_sum, out_cout and out_ovf SHALL stay stable until out_valid && out_ready.
REQ-019 On the out_valid && out_ready edge the FSM SHALL return to IDLE, with in_ready rising the following cycle; there is no same-cycle re-accept.
REQ-020 out_cout SHALL be the carry out of word NWORDS-1, and out_ovf SHALL be (carry into bit 31 of the top word) XOR (carry out of the top word).
REQ-021 The word index SHALL be ceil(log2(NWORDS)) bits wide and SHALL never exceed NWORDS-1.
REQ-022 in_valid, in_a and in_b SHALL be ignored outside IDLE.
REQ-023 out_ready SHALL be ignored outside DONE.

Reset
REQ-024 rst_n low SHALL immediately force the FSM to IDLE, clear the word index and carry, and zero out_sum, out_cout and out_ovf.
REQ-025 rst_n low SHALL also drive out_valid and busy to 0 and in_ready to 1 after deassertion.
REQ-026 A reset asserted during RUN or DONE SHALL discard the partial result without emitting it.
REQ-027 The first request after rst_n deasserts SHALL be acceptable on the first rising edge.

Configuration
REQ-028 With macro FULLADDER32_SEQ_SUB_EN defined, the block SHALL add port in_sub, input, 1 bit, registered at acceptance.
REQ-029 With in_sub high, the block SHALL invert every word of b and force the initial carry to 1 (in_cin ignored), giving out_sum = a - b mod 2^(32*NWORDS).
REQ-030 In subtract mode, out_cout SHALL be 1 when no borrow occurs, and out_ovf SHALL use the same signed rule as REQ-020.
REQ-031 Without FULLADDER32_SEQ_SUB_EN, in_sub SHALL not exist and the block SHALL perform addition only.

Verification (NWORDS=4)
REQ-032 Reset, then a=0, b=0, cin=0 accepted: out_valid SHALL be high 4 cycles later with sum=0, cout=0 and ovf=0.
REQ-033 a=2^128-1, b=0, cin=1: the carry SHALL ripple through all words, giving sum=0 and cout=1.
REQ-034 a=0x7FFF...F (128-bit), b=1: the result SHALL be sum=0x8000...0, ovf=1 and cout=0.
REQ-035 With out_ready held low for 10 cycles in DONE, out_sum SHALL stay stable and in_ready SHALL stay low; after out_ready pulses, in_ready SHALL rise on the next cycle.
REQ-036 rst_n pulsed low during RUN word 2: all outputs SHALL be zero immediately, and the next request SHALL complete correctly.
REQ-037 With FULLADDER32_SEQ_SUB_EN and in_sub=1, a=5, b=7: the result SHALL be sum=2^128-2 and cout=0; then 1000 random adds SHALL match a 128-bit reference model.

Source files
------------

// File: rtl/fulladder32_seq_ctrl.sv
// ============================================================================
// Module   : fulladder32_seq_ctrl
// Brief    : Adds NWORDS-wide operands by running them one 32-bit word per
//            cycle through a single FullAdder32. Subtract mode is enabled by
//            the optional macro FULLADDER32_SEQ_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module FullAdder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module fulladder32_seq_ctrl #(
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [32*NWORDS-1:0]   in_a,
    input  logic [32*NWORDS-1:0]   in_b,
    input  logic                   in_cin,
`ifdef FULLADDER32_SEQ_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*NWORDS-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);
    localparam int              IW         = $clog2(NWORDS);
    localparam logic [IW-1:0]   c_LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic                   r_carry;
    logic [32*NWORDS-1:0]   r_a;
    logic [32*NWORDS-1:0]   r_b;
    logic [32*NWORDS-1:0]   r_sum;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;

    logic [31:0]            w_a_word;
    logic [31:0]            w_b_word;
    logic [31:0]            w_b_inv;
    logic [31:0]            w_sum_word;
    logic                   w_cout;
    logic                   w_c31;
    logic                   w_init_carry;

`ifdef FULLADDER32_SEQ_SUB_EN
    logic                   r_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (r_state == S_IDLE && in_valid && r_in_ready) begin
            r_sub <= in_sub;
        end
    end

    // Two's-complement subtract: invert b word by word, start with carry 1.
    assign w_b_inv      = {32{r_sub}};
    assign w_init_carry = in_sub ? 1'b1 : in_cin;
`else
    assign w_b_inv      = 32'd0;
    assign w_init_carry = in_cin;
`endif

    assign w_a_word = r_a[r_idx*32 +: 32];
    assign w_b_word = r_b[r_idx*32 +: 32] ^ w_b_inv;

    FullAdder32 u_add (
        .a    (w_a_word),
        .b    (w_b_word),
        .cin  (r_carry),
        .sum  (w_sum_word),
        .cout (w_cout)
    );

    // Carry into bit 31 recovered from the sum bit: a ^ b ^ c_in = s.
    assign w_c31 = w_a_word[31] ^ w_b_word[31] ^ w_sum_word[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= w_init_carry;
                        r_idx      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*32 +: 32] <= w_sum_word;
                    r_carry               <= w_cout;
                    if (r_idx == c_LAST_IDX) begin
                        r_cout      <= w_cout;
                        r_ovf       <= w_c31 ^ w_cout;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fulladder32_seq_ctrl.sv
// ============================================================================
// Module   : tb_fulladder32_seq_ctrl
// Brief    : Directed and random self-checking bench for fulladder32_seq_ctrl
//            with a 128-bit reference model feeding a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fulladder32_seq_ctrl;
    localparam int NWORDS = 4;
    localparam int W      = 32 * NWORDS;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;
`ifdef FULLADDER32_SEQ_SUB_EN
    logic           in_sub;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic           out_cout;
    logic           out_ovf;
    logic           busy;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    fulladder32_seq_ctrl #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef FULLADDER32_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         m;
        logic [W:0]   r;
        logic [W-1:0] bb;
        logic         c;
        bb    = sub ? ~b : b;
        c     = sub ? 1'b1 : cin;
        r     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        m.sum  = r[W-1:0];
        m.cout = r[W];
        m.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return m;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge and let it be taken on the next edge.
    // With noise set, in_valid stays high with junk operands while busy.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit noise);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
`ifdef FULLADDER32_SEQ_SUB_EN
        in_sub   = sub;
`endif
        in_valid = 1'b1;
        check("in_ready_idle", W'(in_ready), W'(1));
        @(posedge clk);
        q.push_back(model(a, b, cin, sub));
        #1;
        if (noise) begin
            in_a   = {$urandom, $urandom, $urandom, $urandom};
            in_b   = {$urandom, $urandom, $urandom, $urandom};
            in_cin = ~cin;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        repeat (NWORDS - 1) @(posedge clk);
        #1;
        check("valid_before_latency", W'(out_valid), W'(0));
        check("busy_in_run", W'(busy), W'(1));
        check("in_ready_in_run", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        check("valid_at_latency", W'(out_valid), W'(1));
    endtask

    task automatic receive();
        exp_t e;
        check("scoreboard_nonempty", W'(q.size() != 0), W'(1));
        if (q.size() != 0) begin
            e = q.pop_front();
            check("out_sum", out_sum, e.sum);
            check("out_cout", W'(out_cout), W'(e.cout));
            check("out_ovf", W'(out_ovf), W'(e.ovf));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_after_take", W'(out_valid), W'(0));
        check("in_ready_after_take", W'(in_ready), W'(1));
        check("busy_after_take", W'(busy), W'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        check({tag, "_out_valid"}, W'(out_valid), W'(0));
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_sum"}, out_sum, '0);
        check({tag, "_cout"}, W'(out_cout), W'(0));
        check({tag, "_ovf"}, W'(out_ovf), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef FULLADDER32_SEQ_SUB_EN
        in_sub    = 1'b0;
`endif
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // All-zero operands, accepted on the first edge after reset release.
        accept('0, '0, 1'b0, 1'b0, 1'b0);
        wait_done();
        receive();

        // Full-length carry ripple, with junk on the inputs while busy.
        accept({W{1'b1}}, '0, 1'b1, 1'b0, 1'b1);
        wait_done();
        receive();

        // Signed overflow at the top word; result held while consumer stalls.
        accept({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, 1'b0);
        wait_done();
        out_ready = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("stall_sum", out_sum, {1'b1, {(W-1){1'b0}}});
            check("stall_ovf", W'(out_ovf), W'(1));
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_in_ready", W'(in_ready), W'(0));
        end
        receive();

        // Reset while word 2 is in the adder discards the partial result.
        accept({W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        accept(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'h8000_0000_FFFF_FFFF_0000_0001_8000_0000, 1'b1, 1'b0, 1'b0);
        wait_done();
        receive();

`ifdef FULLADDER32_SEQ_SUB_EN
        accept(W'(5), W'(7), 1'b0, 1'b1, 1'b0);
        wait_done();
        check("sub_sum", out_sum, {{(W-1){1'b1}}, 1'b0});
        check("sub_cout", W'(out_cout), W'(0));
        receive();
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
`ifdef FULLADDER32_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            accept(ra, rb, rc, rs, 1'b0);
            wait_done();
            receive();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
